regfile: RTL and testbench

- 32-entry × 32-bit general-purpose register file for the MIPS datapath core.
- Two asynchronous (combinational) read ports serve the decode stage; one synchronous write port serves writeback.
- Register 0 is hardwired to zero, per MIPS convention.

---
 rtl/regfile.sv | 46 ++++
 tb/tb_regfile.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// MIPS general-purpose register file: 2^ADDR_WIDTH x DATA_WIDTH, two combinational
// read ports and one synchronous write port. Register 0 is hardwired to zero.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read1_num,
  input  logic [ADDR_WIDTH-1:0] read2_num,
  input  logic [ADDR_WIDTH-1:0] write_num,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  output logic [DATA_WIDTH-1:0] read1_data,
  output logic [DATA_WIDTH-1:0] read2_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Register 0 has no storage; the array starts at index 1.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

  // NOTE: the array is reset explicitly because software relies on every register
  // reading 0 after reset; this costs a clear path per flop, so it is not an
  // ordinary RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        // NOTE: non-blocking assignment for all clocked state, so that reads of
        // regs elsewhere see pre-edge values and simulation matches hardware.
        regs[i] <= '0;
      end
    end else if (write_en && (write_num != '0)) begin
      regs[write_num] <= write_data;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  always_comb begin
    read1_data = '0;
    read2_data = '0;
    if (read1_num != '0) read1_data = regs[read1_num];
    if (read2_num != '0) read2_data = regs[read2_num];
  end

endmodule

// File: tb/tb_regfile.sv
// Directed-vector bench for regfile: stimulus pushes expected read values into a
// scoreboard queue, and an independent monitor pops and compares on each sample.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read1_num, read2_num, write_num;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] read1_data, read2_data;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } sb_item_t;

  sb_item_t sb_q [$];
  event     sample_ev;
  int       checks = 0;
  int       errors = 0;

  regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .read1_num  (read1_num),
    .read2_num  (read2_num),
    .write_num  (write_num),
    .write_data (write_data),
    .write_en   (write_en),
    .read1_data (read1_data),
    .read2_data (read2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares the DUT read ports against the oldest scoreboard entry.
  initial begin
    sb_item_t it;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        it = sb_q.pop_front();
        check({it.name, "_rd1"}, read1_data, it.exp1);
        check({it.name, "_rd2"}, read2_data, it.exp2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input string name, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
    sb_item_t it;
    read1_num = a1;
    read2_num = a2;
    it.name = name;
    it.exp1 = e1;
    it.exp2 = e2;
    sb_q.push_back(it);
    #1;
    -> sample_ev;
    #1;
  endtask

  task automatic do_write(input logic [4:0] num, input logic [31:0] data);
    write_num  = num;
    write_data = data;
    write_en   = 1'b1;
    tick();
    write_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; write_en = 1'b0; write_num = '0; write_data = '0;
    read1_num = '0; read2_num = '0;
    #2;

    // Reset then read
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample("reset_read", 5'd5, 5'd31, 32'h0, 32'h0);

    // Basic write/read
    do_write(5'd3, 32'hDEADBEEF);
    sample("basic_wr", 5'd3, 5'd4, 32'hDEADBEEF, 32'h0);

    // Register 0 immutable
    do_write(5'd0, 32'hFFFFFFFF);
    sample("reg0_zero", 5'd0, 5'd0, 32'h0, 32'h0);

    // Write-enable gating
    do_write(5'd7, 32'h12345678);
    write_num = 5'd7; write_data = 32'hAAAAAAAA; write_en = 1'b0;
    tick();
    sample("we_gate", 5'd7, 5'd3, 32'h12345678, 32'hDEADBEEF);

    // Read-during-write: old value before the edge, new value after
    do_write(5'd10, 32'h00000001);
    write_num = 5'd10; write_data = 32'h00000002; write_en = 1'b1;
    sample("rdw_before", 5'd10, 5'd10, 32'h00000001, 32'h00000001);
    tick();
    write_en = 1'b0;
    sample("rdw_after", 5'd10, 5'd10, 32'h00000002, 32'h00000002);

    // Full sweep: addresses change with no clock dependency
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000_0000 + 32'(i));
    for (int i = 1; i < 32; i++)
      sample($sformatf("sweep_%0d", i), 5'(i), 5'(32 - i),
             32'h1000_0000 + 32'(i), 32'h1000_0000 + 32'(32 - i));

    // Reset priority over a same-edge write
    rst = 1'b1; write_en = 1'b1; write_num = 5'd9; write_data = 32'h55555555;
    tick();
    rst = 1'b0; write_en = 1'b0;
    sample("rst_prio_r9", 5'd9, 5'd0, 32'h0, 32'h0);
    for (int i = 1; i < 32; i++)
      sample($sformatf("rst_all_%0d", i), 5'(i), 5'(32 - i), 32'h0, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
